// File: rtl/stall_controller_pkg.sv
// Shared types and constants for the single-cycle stall controller.
// The ERROR state is only present when STALL_TIMEOUT_EN is defined.
package stall_controller_pkg;

    localparam logic [6:0]  OPCODE_LOAD          = 7'b0000011;
    localparam logic [6:0]  OPCODE_STORE         = 7'b0100011;
    localparam logic [31:0] DEFAULT_INITIAL_INST = 32'h00000013;

    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        EXECUTE   = 3'd1,
        DMEM      = 3'd2,
        WRITEBACK = 3'd3
`ifdef STALL_TIMEOUT_EN
        ,
        ERROR     = 3'd4
`endif
    } stall_state_t;

    function automatic logic is_mem_op(input logic [6:0] opcode);
        return (opcode == OPCODE_LOAD) || (opcode == OPCODE_STORE);
    endfunction

endpackage

// File: rtl/stall_timeout_counter.sv
// Wait-cycle counter: counts stalled cycles and flags when TIMEOUT_CYCLES is reached.
// Used only when STALL_TIMEOUT_EN is defined.
module stall_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam int W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    logic [W-1:0] count;

    assign terminal = (count == W'(TIMEOUT_CYCLES));

    // Holding at the terminal value keeps the count from wrapping.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !terminal) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/singlecycle_stall_controller.sv
// Sequences fetch and data accesses over req/ack buses and gates commit enables
// so architectural state updates once per instruction. Optional timeout: STALL_TIMEOUT_EN.
module singlecycle_stall_controller
    import stall_controller_pkg::*;
#(
    parameter logic [31:0] INITIAL_INST   = DEFAULT_INITIAL_INST,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         pc_write_enable_in,
    input  logic         regfile_write_enable_in,
    output logic         pc_write_enable,
    output logic         regfile_write_enable,
    output logic         imem_req,
    input  logic         imem_ack,
    input  logic [31:0]  imem_rdata,
    output logic [31:0]  inst,
    output logic         dmem_req,
    output logic         dmem_we,
    input  logic         dmem_ack,
    input  logic [31:0]  dmem_rdata,
    output logic [31:0]  data_mem_read_data,
    output logic         bus_error,
    output stall_state_t state_debug
);

    // Handshake: a request is held high until the cycle its ack is sampled on a
    // rising edge; ack may arrive in the first request cycle; acks are ignored
    // whenever the matching request is low.

    stall_state_t state, state_next;
    logic         commit;
    logic         timeout_hit;

    assign state_debug = state;

`ifdef STALL_TIMEOUT_EN
    logic waiting;
    assign waiting = ((state == FETCH) && !imem_ack) || ((state == DMEM) && !dmem_ack);

    stall_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clock    (clock),
        .reset    (reset),
        .clear    (!((state == FETCH) || (state == DMEM))),
        .enable   (waiting),
        .terminal (timeout_hit)
    );

    assign bus_error = (state == ERROR);
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
    assign timeout_hit    = 1'b0;
    assign bus_error      = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        commit     = 1'b0;
        case (state)
            FETCH: begin
                if (imem_ack) begin
                    state_next = EXECUTE;
                end else if (timeout_hit) begin
`ifdef STALL_TIMEOUT_EN
                    state_next = ERROR;
`endif
                end
            end
            EXECUTE: begin
                if (is_mem_op(inst[6:0])) begin
                    state_next = DMEM;
                end else begin
                    commit     = 1'b1;
                    state_next = FETCH;
                end
            end
            DMEM: begin
                if (dmem_ack) begin
                    state_next = WRITEBACK;
                end else if (timeout_hit) begin
`ifdef STALL_TIMEOUT_EN
                    state_next = ERROR;
`endif
                end
            end
            WRITEBACK: begin
                commit     = 1'b1;
                state_next = FETCH;
            end
`ifdef STALL_TIMEOUT_EN
            ERROR: begin
                state_next = ERROR;
            end
`endif
            default: begin
                state_next = FETCH;
            end
        endcase
    end

    // Requests are qualified by reset so they drop the moment reset asserts.
    assign imem_req             = reset && (state == FETCH);
    assign dmem_req             = reset && (state == DMEM);
    assign dmem_we              = dmem_req && (inst[6:0] == OPCODE_STORE);
    assign pc_write_enable      = commit && pc_write_enable_in;
    assign regfile_write_enable = commit && regfile_write_enable_in;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            inst               <= INITIAL_INST;
            data_mem_read_data <= '0;
        end else begin
            if ((state == FETCH) && imem_ack) begin
                inst <= imem_rdata;
            end
            if ((state == DMEM) && dmem_ack && (inst[6:0] == OPCODE_LOAD)) begin
                data_mem_read_data <= dmem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_singlecycle_stall_controller.sv
// Directed bench for singlecycle_stall_controller; commit checks go through an
// expected queue popped by a monitor. Timeout cases run when STALL_TIMEOUT_EN is defined.
module tb_singlecycle_stall_controller;
    import stall_controller_pkg::*;

`ifdef STALL_TIMEOUT_EN
    localparam int TB_TIMEOUT = 4;
`else
    localparam int TB_TIMEOUT = 255;
`endif

    localparam logic [31:0] I_ADD = 32'h002081B3;
    localparam logic [31:0] I_LW  = 32'h0000A103;
    localparam logic [31:0] I_SW  = 32'h0020A023;
    localparam logic [31:0] I_NOP = 32'h00000013;

    logic         clock;
    logic         reset;
    logic         pc_write_enable_in;
    logic         regfile_write_enable_in;
    logic         pc_write_enable;
    logic         regfile_write_enable;
    logic         imem_req;
    logic         imem_ack;
    logic [31:0]  imem_rdata;
    logic [31:0]  inst;
    logic         dmem_req;
    logic         dmem_we;
    logic         dmem_ack;
    logic [31:0]  dmem_rdata;
    logic [31:0]  data_mem_read_data;
    logic         bus_error;
    stall_state_t state_debug;

    logic [65:0] exp_q[$];
    logic [65:0] mon_exp;
    logic [65:0] mon_got;
    logic [31:0] exp_dmrd;
    int          tests_run;
    int          tests_failed;

    singlecycle_stall_controller #(
        .INITIAL_INST   (32'h00000013),
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut (
        .clock                   (clock),
        .reset                   (reset),
        .pc_write_enable_in      (pc_write_enable_in),
        .regfile_write_enable_in (regfile_write_enable_in),
        .pc_write_enable         (pc_write_enable),
        .regfile_write_enable    (regfile_write_enable),
        .imem_req                (imem_req),
        .imem_ack                (imem_ack),
        .imem_rdata              (imem_rdata),
        .inst                    (inst),
        .dmem_req                (dmem_req),
        .dmem_we                 (dmem_we),
        .dmem_ack                (dmem_ack),
        .dmem_rdata              (dmem_rdata),
        .data_mem_read_data      (data_mem_read_data),
        .bus_error               (bus_error),
        .state_debug             (state_debug)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // commit monitor
    always @(negedge clock) begin
        if (pc_write_enable || regfile_write_enable) begin
            tests_run++;
            mon_got = {pc_write_enable, regfile_write_enable, inst, data_mem_read_data};
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL commit_unexpected: got %h expected no commit", mon_got);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp) begin
                    tests_failed++;
                    $display("FAIL commit_value: got %h expected %h", mon_got, mon_exp);
                end
            end
        end
    end

    // driver: one full instruction, entered and left at #1 after an edge in FETCH
    task automatic run_instr(input logic [31:0] word, input int imem_wait, input int dmem_wait,
                             input logic [31:0] rdata, input logic rf_in);
        logic [6:0] op;
        op = word[6:0];
        pc_write_enable_in      = 1'b1;
        regfile_write_enable_in = rf_in;
        imem_rdata              = word;
        check("fetch_req", 32'(imem_req), 32'd1);
        check("fetch_no_commit", 32'({pc_write_enable, regfile_write_enable}), 32'd0);
        repeat (imem_wait) tick();
        imem_ack = 1'b1;
        tick();
        imem_ack   = 1'b0;
        imem_rdata = 32'hBAD0BAD0;
        check("exec_state", 32'(state_debug), 32'(EXECUTE));
        check("exec_inst", inst, word);
        check("exec_no_imem_req", 32'(imem_req), 32'd0);
        if ((op == OPCODE_LOAD) || (op == OPCODE_STORE)) begin
            tick();
            for (int i = 0; i <= dmem_wait; i++) begin
                check("dmem_req", 32'(dmem_req), 32'd1);
                check("dmem_we", 32'(dmem_we), 32'(op == OPCODE_STORE));
                imem_ack = 1'b1;
                if (i == dmem_wait) begin
                    dmem_ack   = 1'b1;
                    dmem_rdata = rdata;
                end
                tick();
            end
            dmem_ack   = 1'b0;
            imem_ack   = 1'b0;
            dmem_rdata = 32'h0BADF00D;
            if (op == OPCODE_LOAD) exp_dmrd = rdata;
            check("wb_state", 32'(state_debug), 32'(WRITEBACK));
            check("wb_dmem_req_low", 32'(dmem_req), 32'd0);
            check("wb_inst_held", inst, word);
            check("wb_read_data", data_mem_read_data, exp_dmrd);
        end
        exp_q.push_back({1'b1, rf_in, word, exp_dmrd});
        tick();
        check("back_to_fetch", 32'(state_debug), 32'(FETCH));
        check("bus_error_clear", 32'(bus_error), 32'd0);
    endtask

    task automatic spurious_dmem_ack();
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h12345678;
        repeat (2) tick();
        dmem_ack = 1'b0;
        check("spur_state", 32'(state_debug), 32'(FETCH));
        check("spur_read_data", data_mem_read_data, exp_dmrd);
        check("spur_imem_req", 32'(imem_req), 32'd1);
    endtask

    task automatic reset_mid_dmem();
        pc_write_enable_in      = 1'b1;
        regfile_write_enable_in = 1'b1;
        imem_rdata              = I_LW;
        imem_ack                = 1'b1;
        tick();
        imem_ack = 1'b0;
        tick();
        tick();
        check("rst_pre_dmem_req", 32'(dmem_req), 32'd1);
        reset = 1'b0;
        #1;
        exp_dmrd = 32'd0;
        check("rst_dmem_req_drop", 32'(dmem_req), 32'd0);
        check("rst_imem_req_low", 32'(imem_req), 32'd0);
        check("rst_inst", inst, I_NOP);
        check("rst_read_data", data_mem_read_data, 32'd0);
        check("rst_state", 32'(state_debug), 32'(FETCH));
        tick();
        reset = 1'b1;
        #1;
        check("rst_release_req", 32'(imem_req), 32'd1);
    endtask

`ifdef STALL_TIMEOUT_EN
    task automatic timeout_fetch();
        imem_ack = 1'b0;
        repeat (TB_TIMEOUT) tick();
        check("to_still_fetch", 32'(state_debug), 32'(FETCH));
        check("to_no_error_yet", 32'(bus_error), 32'd0);
        tick();
        check("to_bus_error", 32'(bus_error), 32'd1);
        check("to_imem_req_low", 32'(imem_req), 32'd0);
        imem_ack = 1'b1;
        repeat (2) tick();
        imem_ack = 1'b0;
        check("to_error_sticky", 32'(bus_error), 32'd1);
        check("to_req_stays_low", 32'(imem_req), 32'd0);
        reset = 1'b0;
        #1;
        check("to_reset_clears", 32'(bus_error), 32'd0);
        tick();
        reset = 1'b1;
        #1;
    endtask
`endif

    initial begin
        tests_run               = 0;
        tests_failed            = 0;
        exp_dmrd                = 32'd0;
        reset                   = 1'b0;
        pc_write_enable_in      = 1'b1;
        regfile_write_enable_in = 1'b1;
        imem_ack                = 1'b0;
        imem_rdata              = 32'd0;
        dmem_ack                = 1'b0;
        dmem_rdata              = 32'd0;
        repeat (2) tick();
        check("reset_imem_req", 32'(imem_req), 32'd0);
        check("reset_dmem_req", 32'(dmem_req), 32'd0);
        check("reset_enables", 32'({pc_write_enable, regfile_write_enable}), 32'd0);
        check("reset_inst", inst, I_NOP);
        check("reset_read_data", data_mem_read_data, 32'd0);
        check("reset_bus_error", 32'(bus_error), 32'd0);
        reset = 1'b1;
        #1;

        run_instr(I_ADD, 0, 0, 32'd0, 1'b1);
        run_instr(I_LW, 1, 3, 32'hDEADBEEF, 1'b1);
        run_instr(I_SW, 0, 2, 32'h55555555, 1'b0);
        spurious_dmem_ack();
        run_instr(I_ADD, 1, 0, 32'd0, 1'b0);
        run_instr(I_LW, 0, 0, 32'hCAFEF00D, 1'b1);
        reset_mid_dmem();
        run_instr(I_NOP, 0, 0, 32'd0, 1'b1);
        run_instr(I_NOP, TB_TIMEOUT, 0, 32'd0, 1'b1);
`ifdef STALL_TIMEOUT_EN
        timeout_fetch();
        run_instr(I_ADD, TB_TIMEOUT, 0, 32'd0, 1'b1);
`endif
        repeat (2) tick();
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/singlecycle_stall_controller.md
# singlecycle_stall_controller

Bus-side sequencer that lets the single-cycle datapath run against instruction and data memories with variable latency, using req/ack handshakes. It fetches and holds the instruction word. For loads and stores it issues the data access and latches the read data. It gates the core control unit's `pc_write_enable` and `regfile_write_enable` so architectural state commits exactly once per instruction. It sits between the core control unit, the datapath and the two memory ports.

## Interface
Parameters:
- `INITIAL_INST`, default 32'h00000013 (addi x0,x0,0): value of `inst` at reset.
- `TIMEOUT_CYCLES`, default 255: wait cycles before a bus error (used only with the macro).

Ports:
- `clock`, in, 1: the single clock.
- `reset`, in, 1: asynchronous, active-low; 0 = reset.
- `pc_write_enable_in`, in, 1: from the control unit.
- `regfile_write_enable_in`, in, 1: from the control unit.
- `pc_write_enable`, out, 1: gated, to the datapath.
- `regfile_write_enable`, out, 1: gated, to the datapath.
- `imem_req`, out, 1: instruction fetch request.
- `imem_ack`, in, 1: fetch done; `imem_rdata` is valid this cycle.
- `imem_rdata`, in, 32: fetched instruction word.
- `inst`, out, 32: registered instruction, to the datapath.
- `dmem_req`, out, 1: data access request; the address comes from the datapath's `data_mem_address`.
- `dmem_we`, out, 1: 1 = store, 0 = load; valid while `dmem_req` is high.
- `dmem_ack`, in, 1: data access done.
- `dmem_rdata`, in, 32: load data, valid with `dmem_ack`.
- `data_mem_read_data`, out, 32: registered load data, to the datapath.
- `bus_error`, out, 1: sticky timeout flag.

## Operation
- States: FETCH, EXECUTE, DMEM, WRITEBACK, ERROR. ERROR exists only with the macro.
- FETCH
  - `imem_req`=1.
  - On `imem_ack`: `inst` <= `imem_rdata`, go to EXECUTE.
- EXECUTE
  - Decodes `inst[6:0]`.
  - LOAD (0000011) or STORE (0100011): go to DMEM; no enables this cycle.
  - Any other opcode: `pc_write_enable`=`pc_write_enable_in`, `regfile_write_enable`=`regfile_write_enable_in`, then go to FETCH.
- DMEM
  - `dmem_req`=1.
  - `dmem_we`=1 for STORE, 0 for LOAD.
  - On `dmem_ack`: for a LOAD, `data_mem_read_data` <= `dmem_rdata`; go to WRITEBACK.
- WRITEBACK: pass both enables through as in the EXECUTE commit case, then go to FETCH.
- In every other state both gated enables are 0. Commit is therefore exactly one cycle per instruction.
- `inst` is held constant from EXECUTE through WRITEBACK, so the datapath address and write data stay stable during DMEM.
- An ack in a state that is not requesting it is ignored (`imem_ack` outside FETCH, `dmem_ack` outside DMEM).
- Requests are Moore outputs of the state and are forced to 0 while `reset`=0.

## Timing
- Reset values (asynchronous):
  - state = FETCH, `inst` = `INITIAL_INST`.
  - `data_mem_read_data` = 0, `bus_error` = 0.
  - All requests and enables = 0.
- An ack is sampled on the rising edge while its request is high. An ack in the first request cycle is legal (zero wait).
- Minimum latency per instruction:
  - Non-memory: 2 cycles (FETCH, EXECUTE).
  - Load/store: 4 cycles (FETCH, EXECUTE, DMEM, WRITEBACK).
  - Each wait cycle adds 1.
- Reset asserted mid-DMEM or mid-FETCH: the request drops immediately and no commit occurs. After release, fetch restarts from the PC's reset value.
- Each request stays high until its ack; there is no abort.

## Configuration
- `STALL_TIMEOUT_EN` defined:
  - A wait counter clears on entry to FETCH or DMEM and increments each cycle without an ack.
  - When the count equals `TIMEOUT_CYCLES`, the next state is ERROR.
  - If an ack arrives on that same cycle, the ack wins.
  - In ERROR: all requests and enables are 0 and `bus_error`=1 until reset.
- Macro undefined: no counter, no ERROR state, `bus_error` tied to 0, and the block waits indefinitely.

## Structure
- Package `stall_controller_pkg`:
  - State enum `stall_state_t`.
  - `OPCODE_LOAD`, `OPCODE_STORE`.
  - Default `INITIAL_INST` constant.
- Sub-module `stall_timeout_counter`: clear, enable, terminal-count output, parameter `TIMEOUT_CYCLES`. Instantiated only under `STALL_TIMEOUT_EN`.

## Test plan
- Zero-wait ADD (`imem_rdata`=32'h002081B3, `imem_ack`=1 in first FETCH cycle) -> `pc_write_enable`=1 and `regfile_write_enable`=1 in cycle 2 only, then FETCH again.
- LW with `dmem_ack` after 3 wait cycles, `dmem_rdata`=32'hDEADBEEF -> `dmem_req` high for 4 cycles with `dmem_we`=0; `data_mem_read_data`=32'hDEADBEEF in WRITEBACK; enables pulse once.
- SW (32'h0020A023) -> `dmem_we`=1 throughout DMEM; `regfile_write_enable` stays 0 when `regfile_write_enable_in`=0.
- Spurious `dmem_ack` during FETCH -> ignored; `data_mem_read_data` and state unchanged.
- Reset pulled low in the second DMEM cycle -> `dmem_req` drops the same cycle; `inst`=32'h00000013; no enable pulse.
- With `STALL_TIMEOUT_EN` and `TIMEOUT_CYCLES`=4, no `imem_ack` -> `bus_error`=1 after 4 wait cycles, `imem_req` stays 0 until reset; ack on the terminal cycle -> no error.
